i2s_frame_sequencer: RTL and testbench

Sits on the I2S bit-clock domain between the I2S receiver and the S/PDIF transmitter. It checks the ws framing and declares lock once the frame length is stable. It then schedules one capture of the receiver's left/right words per frame and hands the pairs to the transmitter through a 2-entry valid/ready buffer. It also numbers each pair inside the 192-frame S/PDIF block so the transmitter knows where a block starts.

---
 rtl/i2s_frame_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_i2s_frame_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/i2s_frame_sequencer.sv
// i2s_frame_sequencer
//   Runs on the I2S bit clock between the I2S receiver and the S/PDIF transmitter.
//   It checks ws framing, declares lock once the half-frame length is stable, and
//   captures one left/right pair per locked frame. Pairs go to a 2-entry valid/ready
//   buffer, each tagged with whether it is frame 0 of a BLOCK_LEN-frame block.
//
// Ports
//   sck          bit clock (only clock)
//   rst          synchronous active-high reset
//   ws           I2S word select
//   left_in      left word from receiver
//   right_in     right word from receiver
//   pair_valid   buffer head holds a pair
//   pair_ready   transmitter accepts head pair
//   left_out     head pair, left word
//   right_out    head pair, right word
//   block_start  head pair is frame 0 of a block
//   locked       framing is locked
//   overflow     sticky, a pair was dropped
//   drop_cnt     dropped pairs, saturating
//   unlock_cnt   LOCKED->UNLOCKED transitions, saturating
module i2s_frame_sequencer #(
  parameter int unsigned BITS_PER_CH = 32,
  parameter int unsigned LOCK_HALVES = 4,
  parameter int unsigned CAPTURE_DLY = 2,
  parameter int unsigned BLOCK_LEN   = 192,
  parameter int unsigned DW          = 32
) (
  input  logic          sck,
  input  logic          rst,
  input  logic          ws,
  input  logic [DW-1:0] left_in,
  input  logic [DW-1:0] right_in,
  output logic          pair_valid,
  input  logic          pair_ready,
  output logic [DW-1:0] left_out,
  output logic [DW-1:0] right_out,
  output logic          block_start,
  output logic          locked,
  output logic          overflow,
  output logic [7:0]    drop_cnt,
  output logic [7:0]    unlock_cnt
);

  localparam int unsigned IdxW = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam int unsigned EntW = 2 * DW + 1;

  typedef enum logic [1:0] {StUnlocked, StChecking, StLocked} state_e;

  state_e            state_q, state_d;
  logic              ws_q;
  logic [5:0]        hc_q, hc_d;
  logic [3:0]        good_q, good_d;
  logic [5:0]        tmr_q, tmr_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [EntW-1:0]   ent0_q, ent1_q;
  logic [1:0]        cnt_q;

  logic              ws_edge, ws_fall, half_good, timeout;
  logic [6:0]        half_len;
  logic              leave_lock, enter_unlocked;
  logic              push, pop, drop;
  logic [EntW-1:0]   new_ent;

  // Edge detection and half-period measurement
  always_comb begin
    ws_edge   = ws ^ ws_q;
    ws_fall   = ws_q & ~ws;
    half_len  = {1'b0, hc_q} + 7'd1;
    half_good = (half_len == 7'(BITS_PER_CH));
    timeout   = (hc_q == 6'd63);
    if (ws_edge) begin
      hc_d = 6'd0;
    end else if (hc_q == 6'd63) begin
      hc_d = hc_q;
    end else begin
      hc_d = hc_q + 6'd1;
    end
  end

  // Lock FSM
  always_comb begin
    state_d    = state_q;
    good_d     = good_q;
    leave_lock = 1'b0;
    case (state_q)
      StUnlocked: begin
        // The first half after unlock is partial, so it is never judged.
        if (ws_edge) begin
          state_d = StChecking;
          good_d  = 4'd0;
        end
      end
      StChecking: begin
        if (timeout) begin
          state_d = StUnlocked;
        end else if (ws_edge) begin
          if (half_good) begin
            good_d = good_q + 4'd1;
            if ((good_q + 4'd1) == 4'(LOCK_HALVES)) begin
              state_d = StLocked;
            end
          end else begin
            good_d = 4'd0;
          end
        end
      end
      StLocked: begin
        if (timeout || (ws_edge && !half_good)) begin
          state_d    = StUnlocked;
          leave_lock = 1'b1;
        end
      end
      default: state_d = StUnlocked;
    endcase
    enter_unlocked = (state_d == StUnlocked) && (state_q != StUnlocked);
  end

  // Capture timer and frame index. Arming requires being locked before the edge,
  // so the edge that completes lock never arms.
  always_comb begin
    tmr_d = tmr_q;
    push  = 1'b0;
    if (state_d != StLocked) begin
      tmr_d = 6'd0;
    end else if ((state_q == StLocked) && ws_fall) begin
      tmr_d = 6'(CAPTURE_DLY);
    end else if (tmr_q != 6'd0) begin
      tmr_d = tmr_q - 6'd1;
      push  = (tmr_q == 6'd1);
    end

    idx_d = idx_q;
    if (enter_unlocked) begin
      idx_d = '0;
    end else if (push) begin
      idx_d = (idx_q == IdxW'(BLOCK_LEN - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  always_comb begin
    new_ent = {left_in, right_in, (idx_q == '0)};
    pop     = (cnt_q != 2'd0) && pair_ready;
    drop    = push && (cnt_q == 2'd2) && !pop;
  end

  always_ff @(posedge sck) begin
    if (rst) begin
      state_q <= StUnlocked;
      ws_q    <= 1'b0;
      hc_q    <= 6'd0;
      good_q  <= 4'd0;
      tmr_q   <= 6'd0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ws_q    <= ws;
      hc_q    <= hc_d;
      good_q  <= good_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
    end
  end

  // Two-entry FIFO: ent0 is always the head. Contents survive loss of lock.
  always_ff @(posedge sck) begin
    if (rst) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) begin
            ent0_q <= new_ent;
            cnt_q  <= 2'd1;
          end else if (cnt_q == 2'd1) begin
            ent1_q <= new_ent;
            cnt_q  <= 2'd2;
          end
        end
        2'b01: begin
          ent0_q <= ent1_q;
          cnt_q  <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            ent0_q <= new_ent;
          end else begin
            ent0_q <= ent1_q;
            ent1_q <= new_ent;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sck) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_cnt   <= 8'd0;
      unlock_cnt <= 8'd0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
      end
      if (leave_lock && (unlock_cnt != 8'hff)) begin
        unlock_cnt <= unlock_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    pair_valid                          = (cnt_q != 2'd0);
    {left_out, right_out, block_start} = ent0_q;
    locked                              = (state_q == StLocked);
  end

endmodule

// File: tb/tb_i2s_frame_sequencer.sv
module tb_i2s_frame_sequencer;

  logic        sck = 1'b0;
  logic        rst = 1'b1;
  logic        ws = 1'b0;
  logic [31:0] left_in = '0;
  logic [31:0] right_in = '0;
  logic        pair_ready = 1'b1;
  logic        pair_valid;
  logic [31:0] left_out, right_out;
  logic        block_start, locked, overflow;
  logic [7:0]  drop_cnt, unlock_cnt;

  i2s_frame_sequencer dut (
    .sck        (sck),
    .rst        (rst),
    .ws         (ws),
    .left_in    (left_in),
    .right_in   (right_in),
    .pair_valid (pair_valid),
    .pair_ready (pair_ready),
    .left_out   (left_out),
    .right_out  (right_out),
    .block_start(block_start),
    .locked     (locked),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt),
    .unlock_cnt (unlock_cnt)
  );

  always #5 sck = ~sck;

  typedef struct packed {
    logic [31:0] l;
    logic [31:0] r;
    logic        bs;
  } pair_t;

  pair_t exp_q[$];
  int    exp_idx = 0;
  int    n_chk = 0;
  int    n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Scoreboard monitor: every accepted head pair must match the oldest expectation.
  always @(negedge sck) begin
    if (!rst && pair_valid && pair_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pair", {32'd0, left_out}, 64'hffff_ffff_ffff_ffff);
      end else begin
        pair_t e;
        e = exp_q.pop_front();
        chk("pair_left", {32'd0, left_out}, {32'd0, e.l});
        chk("pair_right", {32'd0, right_out}, {32'd0, e.r});
        chk("pair_block_start", {63'd0, block_start}, {63'd0, e.bs});
      end
    end
  end

  task automatic half(input logic v, input int n);
    ws = v;
    repeat (n) @(posedge sck) #1;
  endtask

  // mode 0: no capture expected, 1: captured and accepted, 2: captured and dropped
  task automatic frame(input logic [31:0] l, input logic [31:0] r, input int mode);
    pair_t e;
    left_in  = l;
    right_in = r;
    if (mode == 1) begin
      e = '{l: l, r: r, bs: (exp_idx == 0)};
      exp_q.push_back(e);
    end
    if (mode != 0) exp_idx = (exp_idx + 1) % 192;
    half(1'b1, 32);
    half(1'b0, 32);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, {63'd0, pair_valid}, 64'd0);
    chk({tag, "_locked"}, {63'd0, locked}, 64'd0);
    chk({tag, "_overflow"}, {63'd0, overflow}, 64'd0);
    chk({tag, "_drop_cnt"}, {56'd0, drop_cnt}, 64'd0);
    chk({tag, "_unlock_cnt"}, {56'd0, unlock_cnt}, 64'd0);
    chk({tag, "_data"}, {left_out, right_out}, 64'd0);
    chk({tag, "_block_start"}, {63'd0, block_start}, 64'd0);
  endtask

  initial begin
    pair_t e;

    // 1: reset, lock, first-capture latency
    rst = 1'b1;
    repeat (3) @(posedge sck) #1;
    chk_all_zero("reset");
    rst = 1'b0;
    frame(32'h1111_1111, 32'h2222_2222, 0);
    frame(32'h1111_1111, 32'h2222_2222, 0);
    chk("not_locked_after_3_good", {63'd0, locked}, 64'd0);
    e = '{l: 32'h1111_1111, r: 32'h2222_2222, bs: 1'b1};
    exp_q.push_back(e);
    exp_idx = 1;
    half(1'b1, 32);
    chk("locked_after_4_good", {63'd0, locked}, 64'd1);
    ws = 1'b0;
    @(posedge sck) #1;
    chk("lat_valid_t1", {63'd0, pair_valid}, 64'd0);
    @(posedge sck) #1;
    chk("lat_valid_t2", {63'd0, pair_valid}, 64'd0);
    @(posedge sck) #1;
    chk("lat_valid_t3", {63'd0, pair_valid}, 64'd1);
    chk("lat_block_start", {63'd0, block_start}, 64'd1);
    repeat (29) @(posedge sck) #1;

    // 2: full block plus wrap to the next block start
    for (int i = 0; i < 192; i++) frame(32'ha000_0000 + i, 32'hb000_0000 + i, 1);
    chk("block_no_drop", {56'd0, drop_cnt}, 64'd0);
    chk("block_no_overflow", {63'd0, overflow}, 64'd0);

    // 3: backpressure overflow
    pair_ready = 1'b0;
    frame(32'hc000_0001, 32'hd000_0001, 1);
    frame(32'hc000_0002, 32'hd000_0002, 1);
    frame(32'hc000_0003, 32'hd000_0003, 2);
    frame(32'hc000_0004, 32'hd000_0004, 2);
    chk("ovf_valid", {63'd0, pair_valid}, 64'd1);
    chk("ovf_head", {32'd0, left_out}, {32'd0, 32'hc000_0001});
    chk("ovf_sticky", {63'd0, overflow}, 64'd1);
    chk("ovf_drop_cnt", {56'd0, drop_cnt}, 64'd2);
    pair_ready = 1'b1;
    frame(32'hc000_0005, 32'hd000_0005, 1);

    // 4: full buffer with push and pop in the same cycle
    pair_ready = 1'b0;
    frame(32'he000_0001, 32'hf000_0001, 1);
    frame(32'he000_0002, 32'hf000_0002, 1);
    left_in  = 32'he000_0003;
    right_in = 32'hf000_0003;
    e = '{l: 32'he000_0003, r: 32'hf000_0003, bs: (exp_idx == 0)};
    exp_q.push_back(e);
    exp_idx = (exp_idx + 1) % 192;
    half(1'b1, 32);
    ws = 1'b0;
    @(posedge sck) #1;
    @(posedge sck) #1;
    pair_ready = 1'b1;
    @(posedge sck) #1;
    pair_ready = 1'b0;
    repeat (29) @(posedge sck) #1;
    chk("pp_drop_cnt", {56'd0, drop_cnt}, 64'd2);
    chk("pp_valid", {63'd0, pair_valid}, 64'd1);
    chk("pp_head", {32'd0, left_out}, {32'd0, 32'he000_0002});
    pair_ready = 1'b1;
    frame(32'he000_0004, 32'hf000_0004, 1);

    // 5: short half unlocks, relock restarts the block
    chk("pre_short_locked", {63'd0, locked}, 64'd1);
    half(1'b1, 31);
    chk("short_still_locked", {63'd0, locked}, 64'd1);
    ws = 1'b0;
    @(posedge sck) #1;
    chk("short_unlocked", {63'd0, locked}, 64'd0);
    chk("short_unlock_cnt", {56'd0, unlock_cnt}, 64'd1);
    repeat (31) @(posedge sck) #1;
    exp_idx = 0;
    frame(32'h3333_0001, 32'h4444_0001, 0);
    frame(32'h3333_0002, 32'h4444_0002, 0);
    frame(32'h3333_0003, 32'h4444_0003, 1);
    chk("relock_locked", {63'd0, locked}, 64'd1);

    // 6: timeout while locked, then reset with an armed timer, then CHECKING timeout
    repeat (70) @(posedge sck) #1;
    chk("timeout_unlocked", {63'd0, locked}, 64'd0);
    chk("timeout_unlock_cnt", {56'd0, unlock_cnt}, 64'd2);
    exp_idx = 0;
    frame(32'h5555_0001, 32'h6666_0001, 0);
    frame(32'h5555_0002, 32'h6666_0002, 0);
    frame(32'h5555_0003, 32'h6666_0003, 1);
    left_in  = 32'h7777_7777;
    right_in = 32'h8888_8888;
    half(1'b1, 32);
    chk("armed_locked", {63'd0, locked}, 64'd1);
    ws = 1'b0;
    @(posedge sck) #1;
    rst = 1'b1;
    @(posedge sck) #1;
    chk_all_zero("armed_rst");
    rst = 1'b0;
    repeat (5) @(posedge sck) #1;
    chk("armed_no_push", {63'd0, pair_valid}, 64'd0);
    ws = 1'b1;
    repeat (70) @(posedge sck) #1;
    chk("chk_timeout_no_push", {63'd0, pair_valid}, 64'd0);
    chk("chk_timeout_unlocked", {63'd0, locked}, 64'd0);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
